mdu_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M multiply/divide ops (Funct7=0000001, ALUOp=10), beside the single-cycle ALU.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_iter_core.sv | 87 ++++++++
 rtl/mdu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
//   mdu_op_e      : Funct3 encoding of the M-extension operations
//   mdu_state_e   : sequencer FSM states
//   FUNCT7_MULDIV : Funct7 value that routes an R-type op to this unit
//   ALUOP_MULDIV  : ALUOp value seen alongside FUNCT7_MULDIV
//   is_signed_op(): {src_a signed, src_b signed} for a given op
package mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_MULDIV  = 2'b10;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } mdu_state_e;

  // MUL returns the low half, which is identical for any signedness, so it
  // runs as unsigned.
  function automatic logic [1:0] is_signed_op(mdu_op_e op);
    logic [1:0] sgn;
    case (op)
      OpMulh:        sgn = 2'b11;
      OpMulhsu:      sgn = 2'b10;
      OpDiv, OpRem:  sgn = 2'b11;
      default:       sgn = 2'b00;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative unsigned multiply / restoring divide datapath.
// Works on operand magnitudes only; sign handling lives in the sequencer.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   load_i             : capture op_a_i / op_b_i and clear the partial state
//   step_i             : advance one iteration of both the multiply and divide
//   op_a_i, op_b_i     : multiplier/dividend and multiplicand/divisor magnitudes
//   prod_nxt_o         : 2*WIDTH product after the current step
//   quo_nxt_o          : quotient after the current step
//   rem_nxt_o          : remainder after the current step
// The *_nxt_o outputs let the sequencer capture the final result on the last
// step edge without an extra cycle.
module mdu_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [2*WIDTH-1:0] prod_nxt_o,
  output logic [WIDTH-1:0]   quo_nxt_o,
  output logic [WIDTH-1:0]   rem_nxt_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               fits;

  always_comb begin
    // Shift-add: multiplier sits in the low half and shifts out LSB first.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
    acc_step = {sum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder stays below the divisor, so the shifted
    // value fits WIDTH+1 bits and one extra bit catches the borrow.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, opb_q};
    fits     = ~diff[WIDTH+1];
    rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], fits};

    acc_d = acc_q;
    opb_d = opb_q;
    quo_d = quo_q;
    rem_d = rem_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, op_a_i};
      opb_d = op_b_i;
      quo_d = op_a_i;
      rem_d = '0;
    end else if (step_i) begin
      acc_d = acc_step;
      quo_d = quo_step;
      rem_d = rem_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      opb_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign prod_nxt_o = acc_step;
  assign quo_nxt_o  = quo_step;
  assign rem_nxt_o  = rem_step;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer beside the single-cycle ALU.
// Accepts one op from execute, stalls the pipeline via busy until the result
// is ready, then pulses done for one cycle with the registered result.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : op request, sampled only in IDLE
//   flush          : kill any in-flight op; wins over start
//   Funct3         : M-op select (MUL..REMU)
//   src_a, src_b   : rs1 / rs2 operands
//   busy           : combinational stall request
//   done           : one-cycle result-valid pulse
//   result         : registered result, held until a later op completes
// Build option: define MDU_FAST_MUL_EN to compute MUL* ops with a single
// combinational product (done one cycle after start); divides always iterate.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;

  mdu_op_e            op_in;
  logic [1:0]         sgn;
  logic               a_neg, b_neg, neg_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               b_zero, ovf, special;
  logic [WIDTH-1:0]   special_res;
  logic               fast_hit;
  logic [WIDTH-1:0]   early_res;
  logic               load, step;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   quo_nxt, rem_nxt;

  // Apply the latched result sign to the unsigned datapath output and pick
  // the half / quotient / remainder the op asks for.
  function automatic logic [WIDTH-1:0] fixup(mdu_op_e op, logic neg,
                                             logic [2*WIDTH-1:0] prod,
                                             logic [WIDTH-1:0] quo,
                                             logic [WIDTH-1:0] rem);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   r;
    p = neg ? -prod : prod;
    case (op)
      OpMul:                    r = p[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: r = p[2*WIDTH-1:WIDTH];
      OpDiv, OpDivu:            r = neg ? -quo : quo;
      default:                  r = neg ? -rem : rem;
    endcase
    return r;
  endfunction

  // Operand decode, magnitudes and special-case detection on the start cycle.
  always_comb begin
    op_in  = mdu_op_e'(Funct3);
    sgn    = is_signed_op(op_in);
    a_neg  = sgn[1] & src_a[WIDTH-1];
    b_neg  = sgn[0] & src_b[WIDTH-1];
    mag_a  = a_neg ? -src_a : src_a;
    mag_b  = b_neg ? -src_b : src_b;
    // Remainder takes the dividend's sign; everything else the product sign.
    neg_in = (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);

    b_zero  = (src_b == '0);
    ovf     = Funct3[2] & ~Funct3[0] & (src_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&src_b);
    special = Funct3[2] & (b_zero | ovf);
    if (b_zero) begin
      special_res = Funct3[1] ? src_a : '1;
    end else begin
      special_res = Funct3[1] ? '0 : src_a;
    end
  end

`ifdef MDU_FAST_MUL_EN
  assign fast_hit  = ~Funct3[2];
  assign early_res = special ? special_res
                   : fixup(op_in, neg_in,
                           {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b}, '0, '0);
`else
  assign fast_hit  = 1'b0;
  assign early_res = special_res;
`endif

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (load),
    .step_i    (step),
    .op_a_i    (mag_a),
    .op_b_i    (mag_b),
    .prod_nxt_o(prod_nxt),
    .quo_nxt_o (quo_nxt),
    .rem_nxt_o (rem_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // Next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d  = op_in;
          neg_d = neg_in;
          if (special || fast_hit) begin
            state_d  = StDone;
            result_d = early_res;
          end else begin
            state_d = StCalc;
            cnt_d   = '0;
            load    = 1'b1;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            result_d = fixup(op_q, neg_q, prod_nxt, quo_nxt, rem_nxt);
          end
        end
      end
      // A flush on the done cycle only suppresses the pulse; the result
      // register has already loaded on entry to this state.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = ((state_q == StIdle) && start && !flush) || (state_q == StCalc);
    done = (state_q == StDone) && !flush;
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  Funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] last_exp = '0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  op;
  } exp_t;
  exp_t sb_q[$];

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .Funct3(Funct3),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M semantics from plain wide arithmetic.
  function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'b0, b});
    int ia = a;
    int ib = b;
    logic [63:0] p;
    logic [31:0] r;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == 32'hFFFF_FFFF) ? MIN : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == MIN && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit early_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    bit e;
    e = f[2] && ((b == 0) || (!f[0] && a == MIN && b == 32'hFFFF_FFFF));
`ifdef MDU_FAST_MUL_EN
    e = e || !f[2];
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = MIN;
      3: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("result_op%0d", e.op), result, e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    exp_t e;
    int   exp_busy;
    int   bcnt;
    bit   seen;
    @(posedge clk); #1;
    Funct3 = f; src_a = a; src_b = b; start = 1'b1;
    exp_busy = early_op(f, a, b) ? 1 : W + 1;
    e.res = ref_model(f, a, b);
    e.op  = f;
    e.cyc = cyc + exp_busy;
    sb_q.push_back(e);
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (poke && i == 3) begin
        Funct3 = ~f; src_a = b; src_b = a; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", bcnt, exp_busy);
    last_exp = e.res;
  endtask

  task automatic flush_test();
    int t;
    @(posedge clk); #1;
    Funct3 = 3'b100; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 10) begin
      @(posedge clk); #1;
      start = (cyc == t + 5);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (W + 4) @(negedge clk);
    chk("flush_result_held", result, last_exp);
  endtask

  task automatic start_flush_test();
    @(posedge clk); #1;
    Funct3 = 3'b101; src_a = 32'd100; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("start_flush_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start_flush_not_accepted", 32'(busy), 32'd0);
    repeat (W + 4) @(negedge clk);
    chk("start_flush_result_held", result, last_exp);
  endtask

  task automatic reset_test();
    int t;
    @(posedge clk); #1;
    Funct3 = 3'b000; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midop_reset_result", result, 32'd0);
    chk("midop_reset_busy", 32'(busy), 32'd0);
    last_exp = '0;
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Funct3 = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    mon_en = 1'b1;

    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(3'b100, 32'hFFFF_FFEC, 32'd3, 1'b0);
    issue(3'b110, 32'hFFFF_FFEC, 32'd3, 1'b0);
    issue(3'b101, 32'd123, 32'd0, 1'b0);
    issue(3'b110, 32'd5, 32'd0, 1'b0);
    issue(3'b100, MIN, 32'hFFFF_FFFF, 1'b0);
    issue(3'b110, MIN, 32'hFFFF_FFFF, 1'b0);
    issue(3'b001, MIN, MIN, 1'b0);
    issue(3'b111, 32'd100, 32'd0, 1'b0);
    issue(3'b000, 32'd6, 32'd7, 1'b0);
    issue(3'b101, 32'hDEAD_BEEF, 32'd1234, 1'b1);

    flush_test();
    start_flush_test();
    reset_test();
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
